// File: rtl/arbitro_memoria_pkg.sv
// ============================================================================
// Module   : arbitro_memoria_pkg
// Brief    : Shared types and constants for the program/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbitro_memoria_pkg;

  // Transaction phases: grant decision, memory access, completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } estado_t;

  // Requester codes, also used as the round-robin history value.
  localparam logic CPU  = 1'b0;
  localparam logic HOST = 1'b1;

  // Round robin: on a tie the requester that was not served last wins.
  function automatic logic otro_solicitante(input logic ultimo);
    return ~ultimo;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbitro_memoria_if.sv
// ============================================================================
// Module   : arbitro_memoria_if
// Brief    : Core, loader and memory buses of the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arbitro_memoria_if #(
  parameter int ANCHO_DATOS = 16,
  parameter int ANCHO_DIR   = 4
);

  // Processor core port
  logic                   cpu_req;
  logic                   cpu_wr;
  logic [ANCHO_DIR-1:0]   cpu_dir;
  logic [ANCHO_DATOS-1:0] cpu_dato_w;
  logic [ANCHO_DATOS-1:0] cpu_dato_r;
  logic                   cpu_ack;
  logic                   cpu_espera;

  // Program loader port
  logic                   host_req;
  logic                   host_wr;
  logic [ANCHO_DIR-1:0]   host_dir;
  logic [ANCHO_DATOS-1:0] host_dato_w;
  logic [ANCHO_DATOS-1:0] host_dato_r;
  logic                   host_ack;

  // Memory instance port
  logic                   mem_oe;
  logic                   mem_we;
  logic [ANCHO_DIR-1:0]   mem_dir;
  logic [ANCHO_DATOS-1:0] mem_dato_w;
  logic [ANCHO_DATOS-1:0] mem_dato_r;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_wr, cpu_dir, cpu_dato_w,
    output cpu_dato_r, cpu_ack, cpu_espera,
    input  host_req, host_wr, host_dir, host_dato_w,
    output host_dato_r, host_ack,
    output mem_oe, mem_we, mem_dir, mem_dato_w,
    input  mem_dato_r
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_wr, cpu_dir, cpu_dato_w,
    input  cpu_dato_r, cpu_ack, cpu_espera,
    output host_req, host_wr, host_dir, host_dato_w,
    input  host_dato_r, host_ack,
    input  mem_oe, mem_we, mem_dir, mem_dato_w,
    output mem_dato_r
  );

endinterface

`default_nettype wire

// File: rtl/arbitro_rr2.sv
// ============================================================================
// Module   : arbitro_rr2
// Brief    : Two-way round-robin grant logic with load-mode mask on the core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr2
  import arbitro_memoria_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_carga,       // load mode: core requests are masked
  input  logic i_habilitar,   // grant may be issued this cycle
  input  logic i_req_cpu,
  input  logic i_req_host,
  input  logic i_actualizar,  // transaction completes this cycle
  input  logic i_servido,     // requester of the completing transaction
  output logic o_concede,
  output logic o_ganador
);

  logic r_ultimo;
  logic w_eleg_cpu;
  logic w_eleg_host;

  assign w_eleg_cpu  = i_req_cpu & ~i_carga;
  assign w_eleg_host = i_req_host;

  // Pick the winner: a lone eligible requester, or the one not served last.
  always_comb begin
    o_concede = i_habilitar & (w_eleg_cpu | w_eleg_host);
    o_ganador = CPU;
    if (w_eleg_cpu && w_eleg_host) begin
      o_ganador = otro_solicitante(r_ultimo);
    end else if (w_eleg_host) begin
      o_ganador = HOST;
    end
  end

  // History starts at HOST so the core wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ultimo <= HOST;
    end else if (i_actualizar) begin
      r_ultimo <= i_servido;
    end
  end

endmodule

`default_nettype wire

// File: rtl/arbitro_memoria.sv
// ============================================================================
// Module   : arbitro_memoria
// Brief    : Serialises core and loader accesses to the single program/data
//            memory as IDLE -> ACC -> FIN transactions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int ANCHO_DATOS = 16,
  parameter int ANCHO_DIR   = 4
) (
  input  logic               Reloj,
  input  logic               Reiniciar,
  input  logic               Carga,
  arbitro_memoria_if.slave   bus
);

  estado_t                r_estado;
  estado_t                w_estado_sig;
  logic                   w_concede;
  logic                   w_ganador;
  logic                   w_en_idle;
  logic                   w_en_fin;

  logic                   r_servido;
  logic                   r_wr_lat;
  logic [ANCHO_DIR-1:0]   r_dir_lat;
  logic [ANCHO_DATOS-1:0] r_dato_lat;
  logic [ANCHO_DATOS-1:0] r_cpu_dato_r;
  logic [ANCHO_DATOS-1:0] r_host_dato_r;

  logic                   w_mem_oe;
  logic                   w_mem_we;
  logic                   w_cpu_ack;
  logic                   w_host_ack;

  assign w_en_idle = (r_estado == IDLE);
  assign w_en_fin  = (r_estado == FIN);

  arbitro_rr2 u_rr2 (
    .clk          (Reloj),
    .rst          (Reiniciar),
    .i_carga      (Carga),
    .i_habilitar  (w_en_idle),
    .i_req_cpu    (bus.cpu_req),
    .i_req_host   (bus.host_req),
    .i_actualizar (w_en_fin),
    .i_servido    (r_servido),
    .o_concede    (w_concede),
    .o_ganador    (w_ganador)
  );

  // Transaction state register; reset aborts any access in flight.
  always_ff @(posedge Reloj or posedge Reiniciar) begin
    if (Reiniciar) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next state plus memory strobes and acks decoded from the state only.
  always_comb begin
    w_estado_sig = r_estado;
    w_mem_oe     = 1'b0;
    w_mem_we     = 1'b0;
    w_cpu_ack    = 1'b0;
    w_host_ack   = 1'b0;
    case (r_estado)
      IDLE: begin
        if (w_concede) begin
          w_estado_sig = ACC;
        end
      end
      ACC: begin
        w_mem_oe     = ~r_wr_lat;
        w_mem_we     = r_wr_lat;
        w_estado_sig = FIN;
      end
      FIN: begin
        w_cpu_ack    = (r_servido == CPU);
        w_host_ack   = (r_servido == HOST);
        w_estado_sig = IDLE;
      end
      default: begin
        w_estado_sig = IDLE;
      end
    endcase
  end

  // Latch the winner's command at grant so later input changes are ignored.
  always_ff @(posedge Reloj or posedge Reiniciar) begin
    if (Reiniciar) begin
      r_servido  <= CPU;
      r_wr_lat   <= 1'b0;
      r_dir_lat  <= '0;
      r_dato_lat <= '0;
    end else if (w_en_idle && w_concede) begin
      r_servido <= w_ganador;
      if (w_ganador == CPU) begin
        r_wr_lat   <= bus.cpu_wr;
        r_dir_lat  <= bus.cpu_dir;
        r_dato_lat <= bus.cpu_dato_w;
      end else begin
        r_wr_lat   <= bus.host_wr;
        r_dir_lat  <= bus.host_dir;
        r_dato_lat <= bus.host_dato_w;
      end
    end
  end

  // Capture read data for the served requester at the end of ACC.
  always_ff @(posedge Reloj or posedge Reiniciar) begin
    if (Reiniciar) begin
      r_cpu_dato_r  <= '0;
      r_host_dato_r <= '0;
    end else if ((r_estado == ACC) && !r_wr_lat) begin
      if (r_servido == CPU) begin
        r_cpu_dato_r <= bus.mem_dato_r;
      end else begin
        r_host_dato_r <= bus.mem_dato_r;
      end
    end
  end

  assign bus.mem_oe      = w_mem_oe;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_dir     = r_dir_lat;
  assign bus.mem_dato_w  = r_dato_lat;
  assign bus.cpu_ack     = w_cpu_ack;
  assign bus.host_ack    = w_host_ack;
  assign bus.cpu_dato_r  = r_cpu_dato_r;
  assign bus.host_dato_r = r_host_dato_r;
  assign bus.cpu_espera  = Carga | (bus.cpu_req & ~w_cpu_ack);

endmodule

`default_nettype wire

// File: tb/tb_arbitro_memoria.sv
// ============================================================================
// Module   : tb_arbitro_memoria
// Brief    : Self-checking bench for arbitro_memoria with a memory model and a
//            transaction-level reference model for randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_arbitro_memoria;
  import arbitro_memoria_pkg::*;

  localparam int AD   = 16;
  localparam int AR   = 4;
  localparam int PROF = 16;

  logic Reloj = 1'b0;
  logic Reiniciar = 1'b0;
  logic Carga = 1'b0;
  logic pre = 1'b0;

  logic [AD-1:0] mem [PROF];
  logic [AD-1:0] img [PROF];

  int vectores = 0;
  int fallos   = 0;

  arbitro_memoria_if #(.ANCHO_DATOS(AD), .ANCHO_DIR(AR)) bus ();

  arbitro_memoria #(.ANCHO_DATOS(AD), .ANCHO_DIR(AR)) dut (
    .Reloj     (Reloj),
    .Reiniciar (Reiniciar),
    .Carga     (Carga),
    .bus       (bus)
  );

  always #5 Reloj = ~Reloj;

  // Memory instance: combinational read, write on the clock edge.
  always @(posedge Reloj) begin
    if (pre) begin
      for (int i = 0; i < PROF; i++) mem[i] <= img[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_dir] <= bus.mem_dato_w;
    end
  end
  assign bus.mem_dato_r = mem[bus.mem_dir];

  task automatic ciclo();
    @(negedge Reloj);
  endtask

  task automatic reposo();
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_dir = '0; bus.cpu_dato_w = '0;
    bus.host_req = 1'b0; bus.host_wr = 1'b0; bus.host_dir = '0; bus.host_dato_w = '0;
  endtask

  task automatic precargar();
    pre = 1'b1;
    @(negedge Reloj);
    pre = 1'b0;
  endtask

  task automatic reiniciar_dut();
    Reiniciar = 1'b1;
    @(negedge Reloj);
    @(negedge Reloj);
    Reiniciar = 1'b0;
  endtask

  task automatic test_reset();
    reposo();
    Carga = 1'b0;
    Reiniciar = 1'b1;
    #1;
    vectores++;
    if ({bus.cpu_ack, bus.host_ack, bus.mem_oe, bus.mem_we, bus.cpu_espera} !== 5'b0) begin
      fallos++;
      $display("FAIL reset_ctl: got %b expected 00000",
               {bus.cpu_ack, bus.host_ack, bus.mem_oe, bus.mem_we, bus.cpu_espera});
    end
    vectores++;
    if ({bus.cpu_dato_r, bus.host_dato_r} !== 32'h0) begin
      fallos++;
      $display("FAIL reset_dato_r: got %h/%h expected 0/0", bus.cpu_dato_r, bus.host_dato_r);
    end
    vectores++;
    if ({bus.mem_dir, bus.mem_dato_w} !== 20'h0) begin
      fallos++;
      $display("FAIL reset_mem_bus: got %h/%h expected 0/0", bus.mem_dir, bus.mem_dato_w);
    end
    @(negedge Reloj);
    Reiniciar = 1'b0;
  endtask

  task automatic test_lectura_cpu();
    for (int i = 0; i < PROF; i++) img[i] = 16'(i * 16'h0101);
    img[3] = 16'hBEEF;
    precargar();
    reiniciar_dut();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_dir = 4'd3;
    #1;
    vectores++;
    if (bus.cpu_espera !== 1'b1) begin
      fallos++; $display("FAIL lect_espera_c1: got %b expected 1", bus.cpu_espera);
    end
    ciclo();
    vectores++;
    if ({bus.mem_oe, bus.mem_we, bus.mem_dir, bus.cpu_ack} !== {1'b1, 1'b0, 4'd3, 1'b0}) begin
      fallos++;
      $display("FAIL lect_acc: got oe=%b we=%b dir=%h ack=%b expected oe=1 we=0 dir=3 ack=0",
               bus.mem_oe, bus.mem_we, bus.mem_dir, bus.cpu_ack);
    end
    bus.cpu_dir = 4'd9;
    ciclo();
    vectores++;
    if ({bus.cpu_ack, bus.host_ack, bus.cpu_espera} !== 3'b100) begin
      fallos++;
      $display("FAIL lect_fin: got ack_c=%b ack_h=%b espera=%b expected 1 0 0",
               bus.cpu_ack, bus.host_ack, bus.cpu_espera);
    end
    vectores++;
    if (bus.cpu_dato_r !== 16'hBEEF || bus.host_dato_r !== 16'h0) begin
      fallos++;
      $display("FAIL lect_dato: got cpu=%h host=%h expected beef 0000", bus.cpu_dato_r, bus.host_dato_r);
    end
    bus.cpu_req = 1'b0;
    ciclo();
    vectores++;
    if (bus.cpu_ack !== 1'b0) begin
      fallos++; $display("FAIL lect_ack_pulse: got %b expected 0", bus.cpu_ack);
    end
  endtask

  task automatic test_carga_host();
    int acks = 0;
    int malos_ritmo = 0;
    int malos_cpu = 0;
    Carga = 1'b1;
    bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_dir = 4'd0; bus.host_dato_w = 16'h1234;
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_dir = 4'd0;
    for (int k = 1; k <= 60 && acks < 16; k++) begin
      ciclo();
      if (bus.cpu_ack !== 1'b0 || bus.cpu_espera !== 1'b1) malos_cpu++;
      if (bus.host_ack === 1'b1) begin
        if (k != 2 + 3 * acks) malos_ritmo++;
        acks++;
        if (acks == 16) bus.host_req = 1'b0;
        else bus.host_dir = 4'(acks);
      end
    end
    vectores++;
    if (acks != 16) begin
      fallos++; $display("FAIL carga_acks: got %0d expected 16 within budget", acks);
    end
    vectores++;
    if (malos_ritmo != 0) begin
      fallos++; $display("FAIL carga_ritmo: got %0d off-slot acks expected 0", malos_ritmo);
    end
    vectores++;
    if (malos_cpu != 0) begin
      fallos++; $display("FAIL carga_cpu_bloq: got %0d cycles with ack/no-stall expected 0", malos_cpu);
    end
    for (int i = 0; i < PROF; i++) begin
      vectores++;
      if (mem[i] !== 16'h1234) begin
        fallos++; $display("FAIL carga_mem[%0d]: got %h expected 1234", i, mem[i]);
      end
    end
  endtask

  task automatic test_carga_baja();
    // Core read of dir 0 is still pending from the load-mode test.
    ciclo();
    bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_dir = 4'd9; bus.host_dato_w = 16'h5555;
    ciclo();
    vectores++;
    if ({bus.mem_we, bus.mem_dir, bus.mem_dato_w} !== {1'b1, 4'd9, 16'h5555}) begin
      fallos++;
      $display("FAIL baja_acc: got we=%b dir=%h d=%h expected 1 9 5555", bus.mem_we, bus.mem_dir, bus.mem_dato_w);
    end
    Carga = 1'b0;
    ciclo();
    vectores++;
    if ({bus.host_ack, bus.cpu_ack} !== 2'b10) begin
      fallos++; $display("FAIL baja_fin: got h=%b c=%b expected 1 0", bus.host_ack, bus.cpu_ack);
    end
    bus.host_req = 1'b0;
    ciclo();
    vectores++;
    if ({bus.mem_oe, bus.cpu_espera} !== 2'b01) begin
      fallos++; $display("FAIL baja_idle: got oe=%b espera=%b expected 0 1", bus.mem_oe, bus.cpu_espera);
    end
    ciclo();
    vectores++;
    if ({bus.mem_oe, bus.mem_dir} !== {1'b1, 4'd0}) begin
      fallos++; $display("FAIL baja_cpu_acc: got oe=%b dir=%h expected 1 0", bus.mem_oe, bus.mem_dir);
    end
    ciclo();
    vectores++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_dato_r !== 16'h1234) begin
      fallos++; $display("FAIL baja_cpu_fin: got ack=%b d=%h expected 1 1234", bus.cpu_ack, bus.cpu_dato_r);
    end
    bus.cpu_req = 1'b0;
    ciclo();
  endtask

  task automatic test_alternancia();
    logic ec, eh;
    reiniciar_dut();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_dir = 4'd1;
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_dir = 4'd2;
    for (int k = 1; k <= 12; k++) begin
      ciclo();
      ec = (k == 2) || (k == 8);
      eh = (k == 5) || (k == 11);
      vectores++;
      if ({bus.cpu_ack, bus.host_ack} !== {ec, eh}) begin
        fallos++;
        $display("FAIL alterna_ciclo%0d: got c=%b h=%b expected c=%b h=%b", k, bus.cpu_ack, bus.host_ack, ec, eh);
      end
    end
    reposo();
    ciclo();
  endtask

  task automatic test_reset_acc();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_dir = 4'd5; bus.cpu_dato_w = 16'hDEAD;
    ciclo();
    vectores++;
    if (bus.mem_we !== 1'b1) begin
      fallos++; $display("FAIL rst_acc_we_antes: got %b expected 1", bus.mem_we);
    end
    #2 Reiniciar = 1'b1;
    #1;
    vectores++;
    if ({bus.mem_we, bus.mem_oe, bus.cpu_ack} !== 3'b000) begin
      fallos++;
      $display("FAIL rst_acc_inmediato: got we=%b oe=%b ack=%b expected 0 0 0", bus.mem_we, bus.mem_oe, bus.cpu_ack);
    end
    reposo();
    @(negedge Reloj);
    Reiniciar = 1'b0;
    vectores++;
    if (mem[5] !== 16'h1234 || bus.cpu_ack !== 1'b0) begin
      fallos++; $display("FAIL rst_acc_abort: got mem5=%h ack=%b expected 1234 0", mem[5], bus.cpu_ack);
    end
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_dir = 4'd4;
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_dir = 4'd6;
    ciclo();
    vectores++;
    if ({bus.mem_oe, bus.mem_dir} !== {1'b1, 4'd4}) begin
      fallos++; $display("FAIL rst_empate_acc: got oe=%b dir=%h expected 1 4", bus.mem_oe, bus.mem_dir);
    end
    ciclo();
    vectores++;
    if ({bus.cpu_ack, bus.host_ack} !== 2'b10) begin
      fallos++; $display("FAIL rst_empate_fin: got c=%b h=%b expected 1 0", bus.cpu_ack, bus.host_ack);
    end
    reposo();
    ciclo();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < PROF; i++) img[i] = 16'hF000 | 16'(i);
    img[2] = 16'h5A5A;
    precargar();
    reiniciar_dut();
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_dir = 4'd2;
    ciclo();
    ciclo();
    vectores++;
    if (bus.host_ack !== 1'b1 || bus.host_dato_r !== 16'h5A5A) begin
      fallos++; $display("FAIL b2b_host_lect: got ack=%b d=%h expected 1 5a5a", bus.host_ack, bus.host_dato_r);
    end
    bus.host_wr = 1'b1; bus.host_dir = 4'd7; bus.host_dato_w = 16'h00AA;
    ciclo();
    ciclo();
    vectores++;
    if ({bus.mem_we, bus.mem_dir, bus.mem_dato_w} !== {1'b1, 4'd7, 16'h00AA}) begin
      fallos++;
      $display("FAIL b2b_host_wr: got we=%b dir=%h d=%h expected 1 7 00aa", bus.mem_we, bus.mem_dir, bus.mem_dato_w);
    end
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_dir = 4'd7;
    ciclo();
    bus.host_req = 1'b0;
    ciclo();
    ciclo();
    ciclo();
    vectores++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_dato_r !== 16'h00AA || bus.host_dato_r !== 16'h5A5A) begin
      fallos++;
      $display("FAIL b2b_cpu_lect: got ack=%b cpu=%h host=%h expected 1 00aa 5a5a",
               bus.cpu_ack, bus.cpu_dato_r, bus.host_dato_r);
    end
    reposo();
    ciclo();
  endtask

  // Randomized traffic against a scheduling model: the arbiter is free at
  // libre_en; a grant at cycle k means access at k+1, ack at k+2, free at k+3.
  task automatic test_aleatorio();
    localparam int N = 3000;
    logic [AD-1:0] mem_ref [PROF];
    logic [AD-1:0] dato_r_ref [2];
    bit            pend [2];
    bit            conced [2];
    bit            wr_q [2];
    logic [AR-1:0] dir_q [2];
    logic [AD-1:0] dato_q [2];
    logic [31:0]   rnd;
    int            libre_en, acc_en, ack_en;
    bit            ultimo_ref, serv_ref, wr_t, ack_c, ack_h, e0, e1, g, fin_trafico;
    logic [AR-1:0] dir_t;
    logic [AD-1:0] dato_t;

    reposo();
    Carga = 1'b0;
    for (int i = 0; i < PROF; i++) begin
      rnd = $urandom;
      img[i] = rnd[AD-1:0];
      mem_ref[i] = rnd[AD-1:0];
    end
    precargar();
    reiniciar_dut();
    ultimo_ref = HOST; serv_ref = CPU; wr_t = 1'b0; dir_t = '0; dato_t = '0;
    libre_en = 0; acc_en = -1; ack_en = -1;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; conced[r] = 1'b0; wr_q[r] = 1'b0; dir_q[r] = '0; dato_q[r] = '0;
      dato_r_ref[r] = '0;
    end

    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge Reloj);
      fin_trafico = (k >= N - 16);
      ack_c = (ack_en == k) && (serv_ref == CPU);
      ack_h = (ack_en == k) && (serv_ref == HOST);
      vectores++;
      if ({bus.cpu_ack, bus.host_ack} !== {ack_c, ack_h}) begin
        fallos++;
        $display("FAIL rnd_ack@%0d: got c=%b h=%b expected c=%b h=%b", k, bus.cpu_ack, bus.host_ack, ack_c, ack_h);
      end
      vectores++;
      if ({bus.mem_we, bus.mem_oe} !== {(acc_en == k) && wr_t, (acc_en == k) && !wr_t}) begin
        fallos++;
        $display("FAIL rnd_strobe@%0d: got we=%b oe=%b expected we=%b oe=%b", k, bus.mem_we, bus.mem_oe,
                 (acc_en == k) && wr_t, (acc_en == k) && !wr_t);
      end
      if (acc_en == k) begin
        vectores++;
        if (bus.mem_dir !== dir_t || (wr_t && bus.mem_dato_w !== dato_t)) begin
          fallos++;
          $display("FAIL rnd_bus@%0d: got dir=%h d=%h expected dir=%h d=%h", k, bus.mem_dir, bus.mem_dato_w, dir_t, dato_t);
        end
      end
      vectores++;
      if (bus.cpu_dato_r !== dato_r_ref[0] || bus.host_dato_r !== dato_r_ref[1]) begin
        fallos++;
        $display("FAIL rnd_dato_r@%0d: got %h/%h expected %h/%h", k, bus.cpu_dato_r, bus.host_dato_r,
                 dato_r_ref[0], dato_r_ref[1]);
      end

      if (acc_en == k) begin
        if (wr_t) mem_ref[dir_t] = dato_t;
        else dato_r_ref[serv_ref] = mem_ref[dir_t];
      end
      if (ack_en == k) begin
        pend[serv_ref] = 1'b0;
        conced[serv_ref] = 1'b0;
        ultimo_ref = serv_ref;
      end

      if (fin_trafico) Carga = 1'b0;
      else if ($urandom_range(0, 15) == 0) Carga = ~Carga;
      for (int r = 0; r < 2; r++) begin
        rnd = $urandom;
        if (!pend[r]) begin
          if (!fin_trafico && $urandom_range(0, 2) == 0) begin
            pend[r] = 1'b1; wr_q[r] = rnd[0]; dir_q[r] = rnd[4:1]; dato_q[r] = rnd[31:16];
          end
        end else if (conced[r]) begin
          wr_q[r] = rnd[0]; dir_q[r] = rnd[4:1]; dato_q[r] = rnd[31:16];
        end else if ($urandom_range(0, 19) == 0) begin
          pend[r] = 1'b0;
        end
      end
      bus.cpu_req = pend[0]; bus.cpu_wr = wr_q[0]; bus.cpu_dir = dir_q[0]; bus.cpu_dato_w = dato_q[0];
      bus.host_req = pend[1]; bus.host_wr = wr_q[1]; bus.host_dir = dir_q[1]; bus.host_dato_w = dato_q[1];
      #1;
      vectores++;
      if (bus.cpu_espera !== (Carga || (pend[0] && !ack_c))) begin
        fallos++;
        $display("FAIL rnd_espera@%0d: got %b expected %b", k, bus.cpu_espera, Carga || (pend[0] && !ack_c));
      end

      if (k >= libre_en) begin
        e0 = pend[0] && !Carga;
        e1 = pend[1];
        if (e0 || e1) begin
          g = (e0 && e1) ? ~ultimo_ref : (e0 ? CPU : HOST);
          conced[g] = 1'b1;
          serv_ref = g; wr_t = wr_q[g]; dir_t = dir_q[g]; dato_t = dato_q[g];
          acc_en = k + 1; ack_en = k + 2; libre_en = k + 3;
        end
      end
    end
    reposo();
    ciclo();
    ciclo();
    for (int i = 0; i < PROF; i++) begin
      vectores++;
      if (mem[i] !== mem_ref[i]) begin
        fallos++; $display("FAIL rnd_mem[%0d]: got %h expected %h", i, mem[i], mem_ref[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lectura_cpu();
    test_carga_host();
    test_carga_baja();
    test_alternancia();
    test_reset_acc();
    test_back_to_back();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Arbitrates the single 16x16 program/data memory between two requesters: the processor core (port cpu_*) and the external program loader (port host_*).
- Each access is serialized into a fixed 3-state transaction: IDLE -> ACC -> FIN.
- Sits between the core's memory control signals (oeM/WR/address/data) and the memory instance, replacing their direct connection.
- A load-mode input (Carga) blocks the core and gives the loader exclusive use while a program is downloaded.

Parameters:
- ANCHO_DATOS, 16, data word width.
- ANCHO_DIR, 4, address width (memory depth = 2**ANCHO_DIR).

Ports:
- Reloj  in  1  clock, rising edge.
- Reiniciar  in  1  asynchronous active-high reset.
- Carga  in  1  load mode: 1 = core requests are not granted.
- cpu_req  in  1  core request, level, held until cpu_ack.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_dir  in  ANCHO_DIR  core address.
- cpu_dato_w  in  ANCHO_DATOS  core write data.
- cpu_dato_r  out  ANCHO_DATOS  core read data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_espera  out  1  core must stall.
- host_req, host_wr, host_dir, host_dato_w, host_dato_r, host_ack: same as the cpu_* ports, for the loader.
- mem_oe  out  1  memory read enable.
- mem_we  out  1  memory write enable; memory writes on the Reloj edge.
- mem_dir  out  ANCHO_DIR  memory address.
- mem_dato_w  out  ANCHO_DATOS  memory write data.
- mem_dato_r  in  ANCHO_DATOS  memory read data (combinational from mem_dir).

Behaviour:
- Reset (asynchronous, immediate):
  - estado=IDLE, ultimo=HOST, so the core wins the first tie.
  - All acks 0; cpu_dato_r and host_dato_r 0.
  - mem_oe, mem_we 0; mem_dir, mem_dato_w 0.
- Reset mid-ACC: the transaction is aborted with no ack. mem_we falls immediately because it decodes the state register only.
- IDLE, grant decision each cycle:
  - Eligible requesters: cpu = cpu_req && !Carga; host = host_req.
  - Only one eligible: grant it.
  - Both eligible: grant the one != ultimo (round robin).
  - None eligible: stay in IDLE.
  - On grant: latch wr, dir, dato_w of the winner into internal registers, set servido=winner, go to ACC.
- ACC (1 cycle):
  - mem_dir and mem_dato_w come from the latched registers.
  - mem_oe = !wr_lat; mem_we = wr_lat.
  - For a read, mem_dato_r is captured at the end of the cycle into the served requester's dato_r register.
  - The other requester's dato_r is unchanged.
  - Go to FIN.
- FIN (1 cycle):
  - Served requester's ack = 1; mem_oe = mem_we = 0.
  - ultimo = servido; go to IDLE.
  - A req still high during FIN is not sampled. It is seen as a new request in the following IDLE cycle.
- Latency: request sampled in IDLE cycle N -> memory access in N+1 -> ack in N+2. Throughput: 1 access per 3 cycles.
- dato_r outputs hold their value until the next completed read for that requester; writes leave them unchanged.
- cpu_espera = Carga || (cpu_req && !cpu_ack).
- Carga changes:
  - Never abort an in-flight transaction.
  - Sampled only in IDLE.
  - A core request pending while Carga=1 stays pending, with cpu_espera=1, and is granted in the first IDLE cycle after Carga=0.
- Requester changes:
  - If a requester drops req before being granted, the request is forgotten.
  - Changing dir, data or wr after grant has no effect on the transaction.
- Same-address conflicts (core read vs loader write) are resolved purely by grant order. No forwarding.
- Address range: ANCHO_DIR matches the memory depth, so there is no out-of-range case.
- mem_* outputs are decoded from the state and latched registers only. No combinational path from the req inputs to mem_we.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, ACC=2'd1, FIN=2'd2;
  - requester codes CPU=1'b0, HOST=1'b1.
- One natural sub-module: arbitro_rr2, the 2-way round-robin grant logic with the ultimo register and the Carga mask.
- The transaction FSM and data latches stay in the top.

Test Plan:
- Reset, then cpu_req=1 read dir=3 with mem[3]=16'hBEEF -> mem_oe=1 in the 2nd cycle, cpu_ack pulse in the 3rd cycle, cpu_dato_r=16'hBEEF; host_dato_r stays 0.
- Carga=1, host writes 16'h1234 to dir=0..15 back-to-back with req held high -> one write every 3 cycles, 16 host_acks; a cpu_req raised meanwhile gets no ack, cpu_espera=1.
- cpu_req and host_req both high continuously after reset -> grants alternate CPU, HOST, CPU, HOST; acks at cycles 3, 6, 9, 12.
- Carga drops 0 while a host write is in ACC -> the write completes with host_ack; the pending cpu_req is granted in the next IDLE cycle.
- Reiniciar pulsed during ACC of a cpu write to dir=5 -> mem_we drops immediately, no cpu_ack; after release estado=IDLE and the next tie goes to the core.
- host writes 16'h00AA to dir=7, then core reads dir=7 in the following grant -> cpu_dato_r=16'h00AA; host_dato_r unchanged.
